// File: rtl/pe_op_sequencer.sv
// Purpose: sequences one PE op (mult/cube/add/sub): PE clear, load, run, then capture of PE out.
// Latency: accept edge to done high is MULT_CYCLES+3 edges for mult and 4 edges for the other ops.
// Backpressure: cmd_ready is high only in IDLE; build with PE_SEQ_ABORT_EN for the abort port.
module pe_op_sequencer #(
    parameter int M           = 593,
    parameter int WIDTH       = 2*M-1,
    parameter int WIDTH_D0    = 1187,
    parameter int MULT_CYCLES = 198
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_op,
    input  logic [WIDTH_D0:0]   cmd_a,
    output logic                pe_reset,
    output logic [10:0]         pe_ctrl,
    output logic [WIDTH_D0:0]   pe_d0,
    input  logic [WIDTH:0]      pe_out,
    output logic [WIDTH:0]      result,
    output logic                done
`ifdef PE_SEQ_ABORT_EN
    ,
    input  logic                abort
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_LOAD,
        S_RUN,
        S_CAPT
    } state_t;

    localparam logic [1:0]  OP_MULT   = 2'b00;
    localparam logic [1:0]  OP_CUBE   = 2'b01;
    localparam logic [1:0]  OP_ADD    = 2'b10;
    localparam logic [5:0]  OPC_CUBE  = 6'b010101;
    localparam logic [5:0]  OPC_ADD   = 6'b000101;
    localparam logic [5:0]  OPC_SUB   = 6'b001001;
    localparam logic [10:0] CTRL_LOAD = 11'b11111_000000;
    localparam logic [10:0] CTRL_MULT = 11'b00000_111111;
    localparam logic [10:0] CTRL_CUBE = 11'b00000_000001;
    localparam logic [10:0] CTRL_ADDS = 11'b00000_010001;
    localparam logic [7:0]  RUN_LAST  = 8'(MULT_CYCLES-1);

    state_t               r_state;
    state_t               w_next_state;
    logic [1:0]           r_op;
    logic [7:0]           r_cnt;
    logic [10:0]          w_ctrl_next;
    logic [WIDTH_D0:0]    w_d0_next;
    logic                 w_accept;
    logic                 w_abort;
    logic                 w_capture;

`ifdef PE_SEQ_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    assign cmd_ready = (r_state == S_IDLE);
    assign w_accept  = cmd_valid && cmd_ready;
    // Capture only on a clean exit from CAPT; an abort there drops the result.
    assign w_capture = (r_state == S_CAPT) && !w_abort;

    // Next-state logic; the registered PE controls are derived from the state being entered.
    always_comb begin
        w_next_state = r_state;
        w_ctrl_next  = 11'd0;
        case (r_state)
            S_IDLE: if (w_accept) w_next_state = S_CLR;
            S_CLR:  w_next_state = S_LOAD;
            S_LOAD: w_next_state = S_RUN;
            S_RUN:  if ((r_op != OP_MULT) || (r_cnt == RUN_LAST)) w_next_state = S_CAPT;
            S_CAPT: w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
        if (w_abort && (r_state != S_IDLE)) begin
            w_next_state = S_IDLE;
        end
        case (w_next_state)
            S_LOAD: w_ctrl_next = CTRL_LOAD;
            S_RUN: begin
                case (r_op)
                    OP_MULT: w_ctrl_next = CTRL_MULT;
                    OP_CUBE: w_ctrl_next = CTRL_CUBE;
                    default: w_ctrl_next = CTRL_ADDS;
                endcase
            end
            default: w_ctrl_next = 11'd0;
        endcase
    end

    // Operand/opcode word presented to PE d0 for the accepted command.
    always_comb begin
        w_d0_next = '0;
        case (cmd_op)
            OP_MULT: w_d0_next = cmd_a;
            OP_CUBE: w_d0_next = {OPC_CUBE, {(WIDTH_D0-5){1'b0}}};
            OP_ADD:  w_d0_next = {OPC_ADD,  {(WIDTH_D0-5){1'b0}}};
            default: w_d0_next = {OPC_SUB,  {(WIDTH_D0-5){1'b0}}};
        endcase
    end

    // State, run counter and all registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_op     <= OP_MULT;
            r_cnt    <= 8'd0;
            pe_reset <= 1'b0;
            pe_ctrl  <= 11'd0;
            pe_d0    <= '0;
            result   <= '0;
            done     <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            pe_reset <= (w_next_state == S_CLR);
            pe_ctrl  <= w_ctrl_next;
            done     <= w_capture;
            // Counter restarts on every RUN entry; RUN exits at RUN_LAST so it never wraps.
            r_cnt    <= (r_state == S_RUN) ? r_cnt + 8'd1 : 8'd0;
            if (w_capture) begin
                result <= pe_out;
            end
            if (w_accept) begin
                r_op  <= cmd_op;
                pe_d0 <= w_d0_next;
            end
        end
    end

endmodule

// File: tb/tb_pe_op_sequencer.sv
// Directed bench for pe_op_sequencer: mult, cube, add/sub back-to-back, result hold,
// mid-op reset and (with PE_SEQ_ABORT_EN) abort. Inputs driven and outputs sampled on
// the falling edge; expected values are hand-derived constants.
module tb_pe_op_sequencer;

    localparam int WD0 = 1187;
    localparam int W   = 1185;
    typedef logic [1187:0] word_t;

    localparam logic [WD0:0] D0_CUBE = {6'b010101, 1182'd0};
    localparam logic [WD0:0] D0_ADD  = {6'b000101, 1182'd0};
    localparam logic [WD0:0] D0_SUB  = {6'b001001, 1182'd0};
    localparam logic [WD0:0] A_PAT   = {4'hC, {148{8'hA5}}};
    localparam logic [W:0]   RES_1   = 1186'h1234_5678_9ABC;
    localparam logic [W:0]   RES_2   = {1186{1'b1}};
    localparam logic [W:0]   RES_3   = {1'b1, 1185'h3C3C};
    localparam logic [W:0]   RES_4   = 1186'hF00D;
    localparam logic [W:0]   RES_5A  = {2'b01, {148{8'h5A}}};

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           cmd_valid = 1'b0;
    logic           cmd_ready;
    logic [1:0]     cmd_op = 2'b00;
    logic [WD0:0]   cmd_a = '0;
    logic           pe_reset;
    logic [10:0]    pe_ctrl;
    logic [WD0:0]   pe_d0;
    logic [W:0]     pe_out = '0;
    logic [W:0]     result;
    logic           done;
`ifdef PE_SEQ_ABORT_EN
    logic           abort = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pe_op_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_a     (cmd_a),
        .pe_reset  (pe_reset),
        .pe_ctrl   (pe_ctrl),
        .pe_d0     (pe_d0),
        .pe_out    (pe_out),
        .result    (result),
        .done      (done)
`ifdef PE_SEQ_ABORT_EN
        ,
        .abort     (abort)
`endif
    );

    task automatic check(input string tag, input word_t obs, input word_t exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h (low 100 bits)", tag, obs[99:0], exp[99:0]);
        end
    endtask

    task automatic start_op(input logic [1:0] op, input logic [WD0:0] a);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
    endtask

    // Follows one op from the accept edge to its done cycle; returns at the done negedge.
    // pe_out carries the wanted value only during CAPT, its complement otherwise.
    task automatic follow_op(input logic [WD0:0] exp_d0, input logic [W:0] exp_res,
                             input logic [W:0] prev_res, input int run_len,
                             input logic [10:0] run_ctrl, input bit drop_valid);
        int n;
        @(negedge clk);
        if (drop_valid) begin
            cmd_valid = 1'b0;
            cmd_op    = ~cmd_op;
            cmd_a     = ~cmd_a;
        end
        pe_out = ~exp_res;
        check("clr_pe_reset", word_t'(pe_reset), word_t'(1));
        check("clr_ctrl", word_t'(pe_ctrl), word_t'(0));
        check("clr_ready", word_t'(cmd_ready), word_t'(0));
        check("clr_done", word_t'(done), word_t'(0));
        check("clr_result", word_t'(result), word_t'(prev_res));
        check("clr_d0", word_t'(pe_d0), word_t'(exp_d0));
        @(negedge clk);
        check("load_pe_reset", word_t'(pe_reset), word_t'(0));
        check("load_ctrl", word_t'(pe_ctrl), word_t'(11'h7C0));
        check("load_ready", word_t'(cmd_ready), word_t'(0));
        n = 0;
        @(negedge clk);
        while (pe_ctrl == run_ctrl && n < 300) begin
            n++;
            @(negedge clk);
        end
        check("run_len", word_t'(n), word_t'(run_len));
        check("capt_ctrl", word_t'(pe_ctrl), word_t'(0));
        check("capt_done", word_t'(done), word_t'(0));
        check("capt_d0", word_t'(pe_d0), word_t'(exp_d0));
        check("capt_result", word_t'(result), word_t'(prev_res));
        pe_out = exp_res;
        @(negedge clk);
        check("done_pulse", word_t'(done), word_t'(1));
        check("done_result", word_t'(result), word_t'(exp_res));
        check("done_ctrl", word_t'(pe_ctrl), word_t'(0));
        check("done_ready", word_t'(cmd_ready), word_t'(1));
        pe_out = ~exp_res;
    endtask

    initial begin
        #1;
        check("rst_pe_reset", word_t'(pe_reset), word_t'(0));
        check("rst_ctrl", word_t'(pe_ctrl), word_t'(0));
        check("rst_d0", word_t'(pe_d0), word_t'(0));
        check("rst_result", word_t'(result), word_t'(0));
        check("rst_done", word_t'(done), word_t'(0));
        check("rst_ready", word_t'(cmd_ready), word_t'(1));
        @(negedge clk);
        reset = 1'b1;

        // Mult with zero multiplicand.
        start_op(2'b00, '0);
        follow_op('0, RES_1, '0, 198, 11'h03F, 1'b1);

        // Cube.
        start_op(2'b01, A_PAT);
        follow_op(D0_CUBE, RES_2, RES_1, 1, 11'h001, 1'b1);

        // Add then sub back-to-back with cmd_valid held; second accept in the done cycle.
        start_op(2'b10, A_PAT);
        follow_op(D0_ADD, RES_3, RES_2, 1, 11'h011, 1'b0);
        cmd_op = 2'b11;
        follow_op(D0_SUB, RES_4, RES_3, 1, 11'h011, 1'b1);
        @(negedge clk);
        check("b2b_done_drop", word_t'(done), word_t'(0));
        check("b2b_result_hold", word_t'(result), word_t'(RES_4));

        // Mult with a patterned multiplicand; old result held until the new done.
        start_op(2'b00, A_PAT);
        follow_op(A_PAT, RES_5A, RES_4, 198, 11'h03F, 1'b1);

        // Reset asserted at RUN cycle 100 of a mult.
        start_op(2'b00, A_PAT);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        repeat (101) @(negedge clk);
        check("mid_run_ctrl", word_t'(pe_ctrl), word_t'(11'h03F));
        reset = 1'b0;
        #1;
        check("mrst_ctrl", word_t'(pe_ctrl), word_t'(0));
        check("mrst_pe_reset", word_t'(pe_reset), word_t'(0));
        check("mrst_d0", word_t'(pe_d0), word_t'(0));
        check("mrst_result", word_t'(result), word_t'(0));
        check("mrst_done", word_t'(done), word_t'(0));
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_ready", word_t'(cmd_ready), word_t'(1));
            check("post_rst_done", word_t'(done), word_t'(0));
        end

`ifdef PE_SEQ_ABORT_EN
        // Abort at RUN cycle 50 of a mult: back to IDLE, no done, result kept.
        start_op(2'b01, '0);
        follow_op(D0_CUBE, RES_1, '0, 1, 11'h001, 1'b1);
        start_op(2'b00, A_PAT);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        repeat (51) @(negedge clk);
        check("pre_abort_ctrl", word_t'(pe_ctrl), word_t'(11'h03F));
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_ctrl", word_t'(pe_ctrl), word_t'(0));
        check("abort_pe_reset", word_t'(pe_reset), word_t'(0));
        check("abort_ready", word_t'(cmd_ready), word_t'(1));
        check("abort_done", word_t'(done), word_t'(0));
        check("abort_result", word_t'(result), word_t'(RES_1));
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done) check("abort_no_done", word_t'(done), word_t'(0));
        end
        check("abort_result_end", word_t'(result), word_t'(RES_1));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, want end of test before it");
        $fatal(1);
    end

endmodule
